fpu_addsub_issue_stage: RTL and testbench
=========================================

// Module: fpu_addsub_issue_stage
// PURPOSE
//  Issue/retire wrapper directly upstream and downstream of combinational FloatingPointAddSubComp.
//  Buffers add/sub/compare requests in an operand FIFO and drives the FIFO head onto the adder's io_a/io_b/io_sub/io_comp.
//  Registers io_y, together with the request tag, into a valid/ready result slot, giving the execute pipe a clean registered FP add path.
// PARAMETERS
//  DEPTH  4   operand FIFO entries; power of two, >=2
//  TAG_W  5   request tag width (destination register id), passed through unchanged
// PORTS
//  clock      in   1      rising-edge clock
//  reset_n    in   1      asynchronous, active-low reset
//  in_valid   in   1      request valid
//  in_ready   out  1      FIFO can accept; = (count != DEPTH)
//  in_a       in   32     IEEE-754 single operand A
//  in_b       in   32     IEEE-754 single operand B
//  in_sub     in   1      1 = A-B
//  in_comp    in   1      1 = compare op
//  in_tag     in   TAG_W  request tag
//  fpu_a      out  32     to adder io_a (FIFO head)
//  fpu_b      out  32     to adder io_b (FIFO head)
//  fpu_sub    out  1      to adder io_sub
//  fpu_comp   out  1      to adder io_comp
//  fpu_y      in   32     from adder io_y (combinational in fpu_a/b/sub/comp)
//  out_valid  out  1      result slot full
//  out_ready  in   1      consumer takes result
//  out_y      out  32     registered result
//  out_tag    out  TAG_W  tag of out_y
//  out_nan    out  1      out_y[30:23]==8'hFF && out_y[22:0]!=0
//  count      out  clog2(DEPTH)+1  FIFO occupancy
// BEHAVIOUR
//  Reset (async assert, sync release): wr_ptr=rd_ptr=0, count=0, out_valid=0, out_y=0, out_tag=0, out_nan=0.
//   Reset mid-operation discards all queued and pending results; no partial output.
//  enq = in_valid & in_ready. Writes {a,b,sub,comp,tag} at wr_ptr. wr_ptr wraps DEPTH-1 -> 0.
//  Head drive: when count!=0, fpu_* = entry[rd_ptr]. When count==0, fpu_* = 0. Outputs are registered/mux only, no latch.
//  deq = (count!=0) & (~out_valid | out_ready).
//   On deq: out_y<=fpu_y, out_tag<=head.tag, out_nan<=nan(fpu_y), out_valid<=1, rd_ptr++ (wraps).
//  If out_valid & out_ready & ~deq: out_valid<=0. out_y/out_tag hold their last value.
//  count: +1 on enq only, -1 on deq only, unchanged on both.
//   Enq and deq in the same cycle are legal whenever count!=DEPTH.
//   Full: in_ready=0 even if deq occurs that cycle (no full-bypass).
//   Empty: no deq; an entry enqueued at edge N is first visible on fpu_* after edge N.
//  Latency: request accepted at edge N -> out_valid=1 after edge N+1 (2 cycles min).
//   Throughput is 1 result/cycle while out_ready=1.
//  Ordering: strict FIFO; out_tag sequence equals accept sequence.
//  Back-pressure: out_ready=0 with out_valid=1 freezes out_* and the FIFO head; FIFO fills to DEPTH, then in_ready=0.
//  Adder numeric result is not modified here; fpu_y is registered bit-exact.
// TESTING
//  1) Add 0x3F800000+0x40000000, tag 3, out_ready=1 -> 2 cycles later out_y=0x40400000, out_tag=3, out_nan=0.
//  2) Sub 0x40400000-0x3F800000 (in_sub=1) -> out_y=0x40000000; fpu_sub=1 while that entry is head.
//  3) Back-pressure: out_ready=0, push 5 requests with tags 1..5 -> 1 in out slot, count=4, in_ready=0;
//     release out_ready -> tags 1..5 retire in order on consecutive cycles.
//  4) NaN: a=0x7FC00000, b=0x3F800000 -> out_nan=1, out_y exponent 8'hFF.
//  5) Streaming: valid every cycle for 16 requests, out_ready=1 -> count<=1, 16 results in 16 consecutive cycles, pointers wrap.
//  6) Assert reset_n=0 with count=3, out_valid=1 -> same cycle out_valid=0, count=0; first post-reset request returns its own tag.

Source files
------------

// File: rtl/fpu_addsub_issue_if.sv
// Request/result handshake bundle between the execute pipe and the FP add issue stage.
// master = pipe side (drives requests, accepts results), slave = issue stage.
interface fpu_addsub_issue_if #(
  parameter int TAG_W = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_a;
  logic [31:0]      in_b;
  logic             in_sub;
  logic             in_comp;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_y;
  logic [TAG_W-1:0] out_tag;
  logic             out_nan;

  modport master (
    output in_valid, in_a, in_b, in_sub, in_comp, in_tag, out_ready,
    input  in_ready, out_valid, out_y, out_tag, out_nan
  );

  modport slave (
    input  in_valid, in_a, in_b, in_sub, in_comp, in_tag, out_ready,
    output in_ready, out_valid, out_y, out_tag, out_nan
  );
endinterface

// File: rtl/fpu_addsub_issue_stage.sv
// Operand FIFO feeding a combinational FP add/sub/compare unit,
// with a registered valid/ready result slot carrying the request tag.
module fpu_addsub_issue_stage #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 5,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic                 clock,
  input  logic                 reset_n,
  fpu_addsub_issue_if.slave    bus,
  output logic [31:0]          fpu_a,
  output logic [31:0]          fpu_b,
  output logic                 fpu_sub,
  output logic                 fpu_comp,
  input  logic [31:0]          fpu_y,
  output logic [CW-1:0]        count
);

  typedef struct packed {
    logic [31:0]      a;
    logic [31:0]      b;
    logic             sub;
    logic             comp;
    logic [TAG_W-1:0] tag;
  } entry_t;

  entry_t        mem [DEPTH];
  entry_t        head;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          empty;
  logic          enq;
  logic          deq;

  assign empty        = (count == '0);
  assign bus.in_ready = (count != CW'(DEPTH));
  assign enq          = bus.in_valid & bus.in_ready;
  assign deq          = ~empty & (~bus.out_valid | bus.out_ready);

  // Idle adder inputs are forced to zero so the unit sees a quiet bus.
  assign head     = empty ? '0 : mem[rd_ptr];
  assign fpu_a    = head.a;
  assign fpu_b    = head.b;
  assign fpu_sub  = head.sub;
  assign fpu_comp = head.comp;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (enq) begin
      mem[wr_ptr] <= '{a:    bus.in_a,
                       b:    bus.in_b,
                       sub:  bus.in_sub,
                       comp: bus.in_comp,
                       tag:  bus.in_tag};
    end
  end

  // Power-of-two depth: pointers wrap by natural overflow.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + 1'b1;
      if (deq) rd_ptr <= rd_ptr + 1'b1;
      unique case ({enq, deq})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      bus.out_valid <= 1'b0;
      bus.out_y     <= '0;
      bus.out_tag   <= '0;
      bus.out_nan   <= 1'b0;
    end else if (deq) begin
      bus.out_valid <= 1'b1;
      bus.out_y     <= fpu_y;
      bus.out_tag   <= head.tag;
      bus.out_nan   <= (fpu_y[30:23] == 8'hFF) && (fpu_y[22:0] != '0);
    end else if (bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fpu_addsub_issue_stage.sv
// Self-checking bench: behavioural adder stand-in, queue model of the
// issue stage checked every cycle, plus directed literal scenarios.
module tb_fpu_addsub_issue_stage;
  localparam int DEPTH = 4;
  localparam int TAG_W = 5;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  fpu_addsub_issue_if #(.TAG_W(TAG_W)) bus ();

  logic [31:0] fpu_a, fpu_b, fpu_y;
  logic        fpu_sub, fpu_comp;
  logic [2:0]  count;

  fpu_addsub_issue_stage #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .bus      (bus),
    .fpu_a    (fpu_a),
    .fpu_b    (fpu_b),
    .fpu_sub  (fpu_sub),
    .fpu_comp (fpu_comp),
    .fpu_y    (fpu_y),
    .count    (count)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0]      a;
    logic [31:0]      b;
    logic             sub;
    logic             comp;
    logic [TAG_W-1:0] tag;
  } req_t;

  req_t q[$];
  bit   exp_ov = 0;

  function automatic bit is_nan(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
  endfunction

  function automatic real s2r(input logic [31:0] x);
    logic [10:0] e;
    if (x[30:23] == 8'd0) return 0.0;
    e = {3'b000, x[30:23]} + 11'd896;
    return $bitstoreal({x[31], e, x[22:0], 29'd0});
  endfunction

  function automatic logic [31:0] r2s(input real r);
    logic [63:0] d;
    int e;
    d = $realtobits(r);
    e = int'(d[62:52]) - 896;
    if (e <= 0) return {d[63], 31'd0};
    if (e >= 255) return {d[63], 8'hFF, 23'd0};
    return {d[63], e[7:0], d[51:29]};
  endfunction

  function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b,
                                       input logic sub, input logic comp);
    real ra, rb;
    if (is_nan(a) || is_nan(b)) return 32'h7FC00000;
    ra = s2r(a);
    rb = s2r(b);
    if (comp) return (ra < rb) ? 32'd1 : 32'd0;
    return r2s(sub ? ra - rb : ra + rb);
  endfunction

  always_comb fpu_y = fadd(fpu_a, fpu_b, fpu_sub, fpu_comp);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, expv, $time);
    end
  endtask

  always @(negedge clock) begin
    int hidx, mc;
    bit rdy_m, deq_m;
    req_t h;
    logic [31:0] y;
    if (!reset_n) begin
      q.delete();
      exp_ov = 0;
    end else begin
      hidx = exp_ov ? 1 : 0;
      mc = q.size() - hidx;
      if (mc < 0) mc = 0;
      chk("out_valid", 32'(bus.out_valid), 32'(exp_ov));
      chk("count", 32'(count), 32'(mc));
      rdy_m = (mc != DEPTH);
      chk("in_ready", 32'(bus.in_ready), 32'(rdy_m));
      if (mc > 0) h = q[hidx];
      else h = '{default: 0};
      chk("fpu_a", fpu_a, h.a);
      chk("fpu_b", fpu_b, h.b);
      chk("fpu_sub", 32'(fpu_sub), 32'(h.sub));
      chk("fpu_comp", 32'(fpu_comp), 32'(h.comp));
      if (exp_ov && q.size() > 0) begin
        y = fadd(q[0].a, q[0].b, q[0].sub, q[0].comp);
        chk("out_y", bus.out_y, y);
        chk("out_tag", 32'(bus.out_tag), 32'(q[0].tag));
        chk("out_nan", 32'(bus.out_nan), 32'(is_nan(y)));
      end
      deq_m = (mc > 0) && (!exp_ov || bus.out_ready);
      if (exp_ov && bus.out_ready && q.size() > 0) void'(q.pop_front());
      if (bus.in_valid && rdy_m)
        q.push_back('{bus.in_a, bus.in_b, bus.in_sub, bus.in_comp, bus.in_tag});
      exp_ov = deq_m || (exp_ov && !bus.out_ready);
    end
  end

  function automatic logic [31:0] rnd_op();
    logic [31:0] r;
    r = $urandom;
    if ($urandom_range(0, 15) == 0) return {r[31], 8'hFF, r[22:1], 1'b1};
    return {r[31], 8'($urandom_range(110, 140)), r[22:0]};
  endfunction

  // Caller is at posedge+1; returns at posedge+1 after acceptance.
  task automatic push(input logic [31:0] a, input logic [31:0] b, input logic sub,
                      input logic comp, input logic [TAG_W-1:0] tag);
    bit ok;
    int n;
    n = 0;
    bus.in_a = a;
    bus.in_b = b;
    bus.in_sub = sub;
    bus.in_comp = comp;
    bus.in_tag = tag;
    bus.in_valid = 1'b1;
    do begin
      @(negedge clock);
      ok = bus.in_ready;
      @(posedge clock);
      #1;
      n++;
    end while (!ok && n < 50);
    bus.in_valid = 1'b0;
    if (!ok) chk("push_timeout", 32'd0, 32'd1);
  endtask

  task automatic expect_out(input string nm, input logic [31:0] y,
                            input logic [TAG_W-1:0] tag, input logic nan);
    int n;
    n = 0;
    @(negedge clock);
    while (!bus.out_valid && n < 20) begin
      @(negedge clock);
      n++;
    end
    if (!bus.out_valid) chk({nm, "_timeout"}, 32'd0, 32'd1);
    else begin
      chk({nm, "_y"}, bus.out_y, y);
      chk({nm, "_tag"}, 32'(bus.out_tag), 32'(tag));
      chk({nm, "_nan"}, 32'(bus.out_nan), 32'(nan));
    end
    @(posedge clock);
    #1;
  endtask

  initial begin
    int n;
    bus.in_valid = 0;
    bus.in_a = 0;
    bus.in_b = 0;
    bus.in_sub = 0;
    bus.in_comp = 0;
    bus.in_tag = 0;
    bus.out_ready = 1;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_out_y", bus.out_y, 32'd0);
    reset_n = 1;

    push(32'h3F800000, 32'h40000000, 1'b0, 1'b0, 5'd3);
    expect_out("add", 32'h40400000, 5'd3, 1'b0);

    push(32'h40400000, 32'h3F800000, 1'b1, 1'b0, 5'd9);
    @(negedge clock);
    chk("sub_head_fpu_sub", 32'(fpu_sub), 32'd1);
    expect_out("sub", 32'h40000000, 5'd9, 1'b0);

    push(32'h7FC00000, 32'h3F800000, 1'b0, 1'b0, 5'd4);
    expect_out("nan", 32'h7FC00000, 5'd4, 1'b1);

    bus.out_ready = 0;
    for (int t = 1; t <= 5; t++) push(rnd_op(), rnd_op(), 1'($urandom), 1'b0, 5'(t));
    @(negedge clock);
    chk("bp_count", 32'(count), 32'd4);
    chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
    chk("bp_out_tag", 32'(bus.out_tag), 32'd1);
    @(posedge clock);
    #1;
    bus.out_ready = 1;
    for (int t = 1; t <= 5; t++) begin
      @(negedge clock);
      chk("bp_retire_valid", 32'(bus.out_valid), 32'd1);
      chk("bp_retire_tag", 32'(bus.out_tag), 32'(t));
    end
    @(posedge clock);
    #1;

    fork
      begin
        for (int i = 0; i < 16; i++)
          push(rnd_op(), rnd_op(), 1'($urandom), 1'($urandom), 5'(i + 10));
      end
      begin
        n = 0;
        @(negedge clock);
        while (!bus.out_valid && n < 20) begin
          @(negedge clock);
          n++;
        end
        for (int i = 0; i < 16; i++) begin
          chk("stream_valid", 32'(bus.out_valid), 32'd1);
          chk("stream_tag", 32'(bus.out_tag), 32'(i + 10));
          chk("stream_count_le1", 32'(count <= 3'd1), 32'd1);
          if (i < 15) @(negedge clock);
        end
      end
    join
    @(posedge clock);
    #1;

    repeat (400) begin
      bus.in_valid = ($urandom_range(0, 3) != 0);
      bus.in_a = rnd_op();
      bus.in_b = rnd_op();
      bus.in_sub = 1'($urandom);
      bus.in_comp = ($urandom_range(0, 7) == 0);
      bus.in_tag = 5'($urandom);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clock);
      #1;
    end
    bus.in_valid = 0;
    bus.out_ready = 1;
    repeat (10) @(posedge clock);
    #1;

    bus.out_ready = 0;
    for (int t = 20; t < 24; t++) push(rnd_op(), rnd_op(), 1'b0, 1'b0, 5'(t));
    #2;
    chk("pre_rst_count", 32'(count), 32'd3);
    chk("pre_rst_valid", 32'(bus.out_valid), 32'd1);
    reset_n = 0;
    #1;
    chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_rst_count", 32'(count), 32'd0);
    chk("mid_rst_tag", 32'(bus.out_tag), 32'd0);
    @(posedge clock);
    #1;
    reset_n = 1;
    bus.out_ready = 1;
    push(32'h3F800000, 32'h3F800000, 1'b0, 1'b0, 5'd7);
    expect_out("post_rst", 32'h40000000, 5'd7, 1'b0);

    repeat (3) @(posedge clock);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
